// File: rtl/pmp_checker.sv
// PMP unit: pmpcfg/pmpaddr CSR storage plus a sequential priority scan
// that answers each access request over a valid/ready handshake.
module pmp_checker #(
    parameter int NUM_ENTRIES = 16,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_hit,
    output logic            csr_stall,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [1:0]      req_type,
    input  logic [1:0]      req_priv,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_allow,
    output logic            resp_match,
    output logic [3:0]      resp_idx
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] A_TOR    = 2'd1;
    localparam logic [1:0] A_NA4    = 2'd2;
    localparam logic [1:0] A_NAPOT  = 2'd3;
    localparam logic [4:0] NUM_CFG  = 5'(NUM_ENTRIES / 4);
    localparam logic [4:0] NUM_E    = 5'(NUM_ENTRIES);
    localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);

    logic [7:0]  cfg_q  [NUM_ENTRIES];
    logic [7:0]  cfg_d  [NUM_ENTRIES];
    logic [29:0] addr_q [NUM_ENTRIES];
    logic [29:0] addr_d [NUM_ENTRIES];
    logic [1:0]  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [29:0] wa_q, wa_d;
    logic [1:0]  type_q, type_d, priv_q, priv_d;
    logic        allow_q, allow_d, match_q, match_d;
    logic [3:0]  ridx_q, ridx_d;

    logic                 is_cfg_s, is_addr_s, wr_en_s;
    logic [NUM_ENTRIES:0] tor_lock_s;
    logic [7:0]           cur_cfg_s;
    logic [29:0]          cur_addr_s, lo_addr_s, napot_mask_s;
    logic                 entry_hit_s, perm_s, hit_allow_s;
    logic [1:0]           unused_addr_lsb_s;

    // Reserved bits forced to zero; W without R is not a legal combination.
    function automatic logic [7:0] sanitize_cfg(input logic [7:0] b);
        logic [7:0] r;
        r    = b & 8'h9F;
        r[1] = r[1] & r[0];
        return r;
    endfunction

    assign unused_addr_lsb_s = req_addr[1:0];

    // CSR address decode and combinational readback.
    always_comb begin
        is_cfg_s  = (csr_addr[11:4] == 8'h3A) && (csr_addr[3:2] == 2'b00) &&
                    ({3'b000, csr_addr[1:0]} < NUM_CFG);
        is_addr_s = (csr_addr[11:4] == 8'h3B) && ({1'b0, csr_addr[3:0]} < NUM_E);
        csr_hit   = is_cfg_s | is_addr_s;
        csr_rdata = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            csr_rdata[(e%4)*8 +: 8] = csr_rdata[(e%4)*8 +: 8] |
                ((is_cfg_s && ((4'(e) >> 2) == {2'b00, csr_addr[1:0]})) ? cfg_q[e] : 8'h00);
            csr_rdata = csr_rdata |
                ((is_addr_s && (4'(e) == csr_addr[3:0])) ? {2'b00, addr_q[e]} : 32'h0);
        end
    end

    // CSR writes, honouring per-entry locks and the TOR lock on the lower bound.
    always_comb begin
        wr_en_s    = csr_we & csr_hit & (state_q == ST_IDLE);
        tor_lock_s = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            tor_lock_s[e] = cfg_q[e][7] && (cfg_q[e][4:3] == A_TOR);
        end
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (wr_en_s && is_cfg_s && ((4'(e) >> 2) == {2'b00, csr_addr[1:0]}) && !cfg_q[e][7]) begin
                cfg_d[e] = sanitize_cfg(csr_wdata[(e%4)*8 +: 8]);
            end else begin
                cfg_d[e] = cfg_q[e];
            end
            if (wr_en_s && is_addr_s && (4'(e) == csr_addr[3:0]) && !cfg_q[e][7] && !tor_lock_s[e+1]) begin
                addr_d[e] = csr_wdata[29:0];
            end else begin
                addr_d[e] = addr_q[e];
            end
        end
    end

    // Address match and permission evaluation for the entry under scan.
    always_comb begin
        cur_cfg_s    = cfg_q[idx_q];
        cur_addr_s   = addr_q[idx_q];
        lo_addr_s    = (idx_q == 4'd0) ? 30'd0 : addr_q[idx_q - 4'd1];
        napot_mask_s = cur_addr_s ^ (cur_addr_s + 30'd1);
        case (cur_cfg_s[4:3])
            A_TOR:   entry_hit_s = (wa_q >= lo_addr_s) && (wa_q < cur_addr_s);
            A_NA4:   entry_hit_s = (wa_q == cur_addr_s);
            A_NAPOT: entry_hit_s = ((wa_q & ~napot_mask_s) == (cur_addr_s & ~napot_mask_s));
            default: entry_hit_s = 1'b0;
        endcase
        case (type_q)
            2'd0:    perm_s = cur_cfg_s[0];
            2'd1:    perm_s = cur_cfg_s[1];
            2'd2:    perm_s = cur_cfg_s[2];
            default: perm_s = 1'b0;
        endcase
        if (type_q == 2'd3) begin
            hit_allow_s = 1'b0;
        end else if ((priv_q == 2'd3) && !cur_cfg_s[7]) begin
            hit_allow_s = 1'b1;
        end else begin
            hit_allow_s = perm_s;
        end
    end

    // Request FSM: accept, scan entries lowest index first, hold the response.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wa_d    = wa_q;
        type_d  = type_q;
        priv_d  = priv_q;
        allow_d = allow_q;
        match_d = match_q;
        ridx_d  = ridx_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wa_d    = req_addr[31:2];
                    type_d  = req_type;
                    priv_d  = req_priv;
                    idx_d   = 4'd0;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (entry_hit_s) begin
                    allow_d = hit_allow_s;
                    match_d = 1'b1;
                    ridx_d  = idx_q;
                    state_d = ST_RESP;
                end else if (idx_q == LAST_IDX) begin
                    allow_d = (priv_q == 2'd3) && (type_q != 2'd3);
                    match_d = 1'b0;
                    ridx_d  = 4'd0;
                    state_d = ST_RESP;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                cfg_q[e]  <= 8'h00;
                addr_q[e] <= 30'd0;
            end
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            wa_q    <= 30'd0;
            type_q  <= 2'd0;
            priv_q  <= 2'd0;
            allow_q <= 1'b0;
            match_q <= 1'b0;
            ridx_q  <= 4'd0;
        end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                cfg_q[e]  <= cfg_d[e];
                addr_q[e] <= addr_d[e];
            end
            state_q <= state_d;
            idx_q   <= idx_d;
            wa_q    <= wa_d;
            type_q  <= type_d;
            priv_q  <= priv_d;
            allow_q <= allow_d;
            match_q <= match_d;
            ridx_q  <= ridx_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign csr_stall  = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_allow = allow_q;
    assign resp_match = match_q;
    assign resp_idx   = ridx_q;

endmodule

// File: tb/tb_pmp_checker.sv
// Directed bench for pmp_checker: scoreboard queue of expected responses,
// immediate-assertion comparisons, one summary line.
module tb_pmp_checker;

    logic        clk, rst_n;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_hit, csr_stall;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_type, req_priv;
    logic        resp_valid, resp_ready, resp_allow, resp_match;
    logic [3:0]  resp_idx;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       allow;
        logic       match;
        logic [3:0] idx;
        logic [7:0] lat;
    } exp_t;
    exp_t sb[$];

    pmp_checker #(.NUM_ENTRIES(16), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_hit(csr_hit), .csr_stall(csr_stall),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_type(req_type), .req_priv(req_priv),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_allow(resp_allow),
        .resp_match(resp_match), .resp_idx(resp_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] ed, input logic eh);
        @(negedge clk);
        csr_addr = a;
        #1;
        chk({tag, "_data"}, csr_rdata, ed);
        chk({tag, "_hit"}, 32'(csr_hit), 32'(eh));
    endtask

    task automatic run_req(input string tag, input logic [31:0] a, input logic [1:0] t, input logic [1:0] p,
                           input logic ea, input logic em, input logic [3:0] ei, input int elat);
        exp_t e;
        int   lat;
        sb.push_back('{ea, em, ei, 8'(elat)});
        @(negedge clk);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_type = t; req_priv = p; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        chk({tag, "_allow"}, 32'(resp_allow), 32'(e.allow));
        chk({tag, "_match"}, 32'(resp_match), 32'(e.match));
        chk({tag, "_idx"}, 32'(resp_idx), 32'(e.idx));
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        int   lat;
        logic seen;
        rst_n = 1'b0; csr_we = 1'b0; csr_addr = 12'h000; csr_wdata = 32'h0;
        req_valid = 1'b0; req_addr = 32'h0; req_type = 2'd0; req_priv = 2'd0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_allow", 32'(resp_allow), 32'd0);
        chk("rst_resp_match", 32'(resp_match), 32'd0);
        chk("rst_resp_idx", 32'(resp_idx), 32'd0);
        chk("rst_csr_stall", 32'(csr_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        csr_rd("rst_cfg0", 12'h3A0, 32'h0, 1'b1);
        csr_rd("rst_addr3", 12'h3B3, 32'h0, 1'b1);
        csr_rd("unimpl_cfg4", 12'h3A4, 32'h0, 1'b0);
        run_req("off_u_rd", 32'h8000_0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0, 17);
        run_req("off_m_rd", 32'h8000_0000, 2'd0, 2'd3, 1'b1, 1'b0, 4'd0, 17);

        // NAPOT 4 KiB region at 0x8000_0000, RW.
        csr_wr(12'h3B0, 32'h2000_01FF);
        csr_wr(12'h3A0, 32'h0000_001B);
        csr_rd("napot_cfg0", 12'h3A0, 32'h0000_001B, 1'b1);
        run_req("napot_u_wr", 32'h8000_07FC, 2'd1, 2'd0, 1'b1, 1'b1, 4'd0, 2);
        run_req("napot_u_x", 32'h8000_07FC, 2'd2, 2'd0, 1'b0, 1'b1, 4'd0, 2);
        run_req("napot_out", 32'h8000_1000, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0, 17);

        // TOR entry 2 over [pmpaddr1, pmpaddr2), catch-all NAPOT entry 3.
        csr_wr(12'h3B1, 32'h2000_0000);
        csr_wr(12'h3B2, 32'h2000_0400);
        csr_wr(12'h3B3, 32'h3FFF_FFFF);
        csr_wr(12'h3A0, 32'h180D_0000);
        run_req("tor_rd", 32'h8000_0100, 2'd0, 2'd0, 1'b1, 1'b1, 4'd2, 4);
        run_req("tor_wr", 32'h8000_0100, 2'd1, 2'd0, 1'b0, 1'b1, 4'd2, 4);
        run_req("tor_above", 32'h8000_1000, 2'd0, 2'd0, 1'b0, 1'b1, 4'd3, 5);

        csr_wr(12'h3A1, 32'h0000_0062);
        csr_rd("rsvd_cfg1", 12'h3A1, 32'h0, 1'b1);
        csr_wr(12'h3B6, 32'hFFFF_FFFF);
        csr_rd("addr6_top", 12'h3B6, 32'h3FFF_FFFF, 1'b1);
        csr_wr(12'h3A0, 32'h180D_001F);
        run_req("rwx_u_x", 32'h8000_0000, 2'd2, 2'd0, 1'b1, 1'b1, 4'd0, 2);
        run_req("type3_u", 32'h8000_0000, 2'd3, 2'd0, 1'b0, 1'b1, 4'd0, 2);
        run_req("type3_m", 32'h8000_0000, 2'd3, 2'd3, 1'b0, 1'b1, 4'd0, 2);

        // Response held for 5 cycles while a CSR write waits on the stall.
        sb.push_back('{1'b1, 1'b1, 4'd0, 8'd2});
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h8000_0000; req_type = 2'd0; req_priv = 2'd0; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        csr_we = 1'b1; csr_addr = 12'h3B5; csr_wdata = 32'h0000_0123;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk("hold_lat", 32'(lat), 32'(e.lat));
        for (int h = 0; h < 5; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_allow", 32'(resp_allow), 32'(e.allow));
            chk("hold_idx", 32'(resp_idx), 32'(e.idx));
            chk("hold_stall", 32'(csr_stall), 32'd1);
            chk("hold_addr5", csr_rdata, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rel_stall", 32'(csr_stall), 32'd0);
        chk("rel_valid", 32'(resp_valid), 32'd0);
        chk("rel_addr5_pending", csr_rdata, 32'h0);
        @(posedge clk); #1;
        chk("rel_addr5_applied", csr_rdata, 32'h0000_0123);
        csr_we = 1'b0;

        // Lock entry 0, then lock entry 2 as TOR to freeze pmpaddr1.
        csr_wr(12'h3A0, 32'h180D_0098);
        csr_rd("lock_cfg0", 12'h3A0, 32'h180D_0098, 1'b1);
        run_req("lock_m_rd", 32'h8000_0000, 2'd0, 2'd3, 1'b0, 1'b1, 4'd0, 2);
        csr_wr(12'h3A0, 32'h1B0D_001F);
        csr_rd("lock_cfg0_wr", 12'h3A0, 32'h1B0D_0098, 1'b1);
        csr_wr(12'h3B0, 32'h0);
        csr_rd("lock_addr0", 12'h3B0, 32'h2000_01FF, 1'b1);
        csr_wr(12'h3A0, 32'h1B8D_0000);
        csr_rd("torlock_cfg0", 12'h3A0, 32'h1B8D_0098, 1'b1);
        csr_wr(12'h3B1, 32'h0);
        csr_rd("torlock_addr1", 12'h3B1, 32'h2000_0000, 1'b1);

        // Reset during a scan: no response may appear.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'hF000_0000; req_type = 2'd0; req_priv = 2'd0; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_stall", 32'(csr_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_resp", 32'(seen), 32'd0);
        csr_rd("mid_rst_cfg0", 12'h3A0, 32'h0, 1'b1);
        run_req("post_rst_u", 32'h8000_0000, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
